db_arbiter: RTL and testbench

Data-break arbiter that shares the CPU's single data-break (DMA) channel among up to NREQ device controllers, such as the RK8E disk and future DMA peripherals. It grants one requester at a time using round-robin priority. For the granted requester it latches address, data and direction, then drives the CPU break request until the CPU enters state DB1. It returns a one-cycle acknowledge, plus read data, to the winner. It sits between the device controllers and the CPU break interface, replacing per-device direct `data_break`/`dmaAddr` wiring.

---
 rtl/db_arbiter_pkg.sv | 13 +
 rtl/db_arbiter_rr_pick.sv | 28 ++
 rtl/db_arbiter.sv | 111 +++++++++++
 tb/tb_db_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/db_arbiter_pkg.sv
// Shared types for the data-break arbiter.
// Holds the arbiter state enum and the CPU break state code.
package db_arbiter_pkg;

    localparam logic [4:0] DB1 = 5'd12;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BREAK = 2'd1,
        ARB_DONE  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/db_arbiter_rr_pick.sv
// Round-robin picker: first set req after 'last', wrapping.
// Purely combinational.
module rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      last,
    output logic            any,
    output logic [2:0]      idx
);

    int j;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        any = 1'b0;
        idx = 3'd0;
        j   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(last) + k) % NREQ;
            if (req[j]) begin
                any = 1'b1;
                idx = 3'(j);
            end
        end
    end

endmodule

// File: rtl/db_arbiter.sv
// Shares the CPU data-break channel among NREQ requesters.
// Round-robin grant, latched break fields, one-cycle ack.
module db_arbiter
    import db_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [4:0]       state,
    input  logic [11:0]      mem_rdata,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*15-1:0] req_addr,
    input  logic [NREQ*12-1:0] req_wdata,
    input  logic [NREQ-1:0]  req_write,
    output logic [NREQ-1:0]  ack,
    output logic             err,
    output logic [11:0]      rdata,
    output logic             data_break,
    output logic [14:0]      dmaAddr,
    output logic [11:0]      dmaDOUT,
    output logic             to_mem,
    output logic [2:0]       gnt_id
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_t    r_st;
    logic [2:0]    r_last;
    logic [CW-1:0] r_cnt;

    logic          w_any;
    logic [2:0]    w_idx;
    int            w_sel;
    logic [14:0]   w_addr;
    logic [11:0]   w_wdata;
    logic          w_write;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (req),
        .last (r_last),
        .any  (w_any),
        .idx  (w_idx)
    );

    always_comb begin
        w_sel   = int'(w_idx);
        w_addr  = req_addr[w_sel*15 +: 15];
        w_wdata = req_wdata[w_sel*12 +: 12];
        w_write = req_write[w_sel];
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_st       <= ARB_IDLE;
            r_last     <= 3'(NREQ - 1);
            r_cnt      <= '0;
            ack        <= '0;
            err        <= 1'b0;
            rdata      <= 12'd0;
            data_break <= 1'b0;
            dmaAddr    <= 15'd0;
            dmaDOUT    <= 12'd0;
            to_mem     <= 1'b0;
            gnt_id     <= 3'd0;
        end else begin
            ack <= '0;
            err <= 1'b0;
            unique case (r_st)
                ARB_IDLE: begin
                    if (w_any) begin
                        dmaAddr    <= w_addr;
                        dmaDOUT    <= w_wdata;
                        to_mem     <= w_write;
                        gnt_id     <= w_idx;
                        data_break <= 1'b1;
                        r_cnt      <= '0;
                        r_st       <= ARB_BREAK;
                    end
                end
                ARB_BREAK: begin
                    if (state == DB1) begin
                        rdata      <= mem_rdata;
                        data_break <= 1'b0;
                        ack        <= NREQ'(1) << gnt_id;
                        r_last     <= gnt_id;
                        r_st       <= ARB_DONE;
                    end else if (r_cnt == CW'(TIMEOUT)) begin
                        // CPU never answered: release the channel with err.
                        data_break <= 1'b0;
                        ack        <= NREQ'(1) << gnt_id;
                        err        <= 1'b1;
                        r_last     <= gnt_id;
                        r_st       <= ARB_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ARB_DONE: begin
                    r_st <= ARB_IDLE;
                end
                default: begin
                    r_st <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_db_arbiter.sv
// Scoreboard bench for db_arbiter (NREQ=2, TIMEOUT=15).
// Directed transactions push expected acks; a monitor checks them.
module tb_db_arbiter;
    import db_arbiter_pkg::*;

    typedef struct {
        logic [1:0]  ack;
        logic        err;
        logic        chk_rd;
        logic [11:0] rdata;
        logic [2:0]  gnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [4:0]  st;
    logic [11:0] mem_rdata;
    logic [1:0]  req;
    logic [29:0] req_addr;
    logic [23:0] req_wdata;
    logic [1:0]  req_write;
    logic [1:0]  ack;
    logic        err;
    logic [11:0] rdata;
    logic        data_break;
    logic [14:0] dmaAddr;
    logic [11:0] dmaDOUT;
    logic        to_mem;
    logic [2:0]  gnt_id;

    exp_t q[$];
    int nchk = 0;
    int nerr = 0;

    db_arbiter #(.NREQ(2), .TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .state      (st),
        .mem_rdata  (mem_rdata),
        .req        (req),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_write  (req_write),
        .ack        (ack),
        .err        (err),
        .rdata      (rdata),
        .data_break (data_break),
        .dmaAddr    (dmaAddr),
        .dmaDOUT    (dmaDOUT),
        .to_mem     (to_mem),
        .gnt_id     (gnt_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest expected completion.
    always @(negedge clk) begin
        if (ack !== 2'b00) begin
            exp_t e;
            nchk++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_ack: got ack=%0b err=%0b expected none",
                         ack, err);
            end else begin
                e = q.pop_front();
                if (ack !== e.ack || err !== e.err || gnt_id !== e.gnt ||
                    (e.chk_rd && rdata !== e.rdata)) begin
                    nerr++;
                    $display("FAIL sb_ack: got ack=%0b err=%0b gnt=%0d rdata=%0o expected ack=%0b err=%0b gnt=%0d rdata=%0o",
                             ack, err, gnt_id, rdata, e.ack, e.err, e.gnt, e.rdata);
                end
            end
            chk("ack_matches_gnt", 32'(ack), 32'(2'b01 << gnt_id));
        end
    end

    task automatic wait_grant(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!data_break && n < 20);
        chk("grant_latency", 32'(n), 32'd1);
    endtask

    task automatic txn(input int id, input logic [14:0] a,
                       input logic [11:0] wd, input logic w,
                       input int dly, input logic [11:0] md,
                       input logic [1:0] others);
        int n;
        req_addr[id*15 +: 15] = a;
        req_wdata[id*12 +: 12] = wd;
        req_write[id] = w;
        req = req | (2'b01 << id) | others;
        q.push_back('{ack: 2'b01 << id, err: 1'b0, chk_rd: 1'b1,
                      rdata: md, gnt: 3'(id)});
        wait_grant(n);
        chk("gnt_id", 32'(gnt_id), 32'(id));
        chk("dmaAddr", 32'(dmaAddr), 32'(a));
        chk("dmaDOUT", 32'(dmaDOUT), 32'(wd));
        chk("to_mem", 32'(to_mem), 32'(w));
        repeat (dly) @(negedge clk);
        chk("break_held", 32'(data_break), 32'd1);
        st = DB1;
        mem_rdata = md;
        @(negedge clk);
        chk("break_drop", 32'(data_break), 32'd0);
        chk("ack_now", 32'(ack), 32'(2'b01 << id));
        req[id] = 1'b0;
        st = 5'd0;
        mem_rdata = 12'd0;
        @(negedge clk);
        chk("ack_clear", 32'(ack), 32'd0);
    endtask

    initial begin
        int n;
        int cyc;
        reset = 1'b1;
        clear = 1'b0;
        st = 5'd0;
        mem_rdata = 12'd0;
        req = 2'b00;
        req_addr = '0;
        req_wdata = '0;
        req_write = '0;
        repeat (2) @(negedge clk);
        chk("rst_break", 32'(data_break), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_addr", 32'(dmaAddr), 32'd0);
        chk("rst_gnt", 32'(gnt_id), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single write by requester 0, DB1 three cycles later.
        txn(0, 15'o12345, 12'o7070, 1'b1, 3, 12'o0000, 2'b00);
        // Read by requester 1.
        txn(1, 15'o01234, 12'o0000, 1'b0, 2, 12'o4321, 2'b00);

        // Round-robin with both requesting.
        txn(0, 15'o00100, 12'o0001, 1'b1, 1, 12'o0011, 2'b10);
        txn(1, 15'o00200, 12'o0002, 1'b0, 2, 12'o0022, 2'b01);
        txn(0, 15'o00300, 12'o0003, 1'b1, 1, 12'o0033, 2'b10);
        txn(1, 15'o00400, 12'o0004, 1'b0, 1, 12'o0044, 2'b00);

        // Timeout on requester 0.
        req_addr[14:0] = 15'o07777;
        req_write[0] = 1'b0;
        req[0] = 1'b1;
        q.push_back('{ack: 2'b01, err: 1'b1, chk_rd: 1'b0,
                      rdata: 12'd0, gnt: 3'd0});
        wait_grant(n);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ack == 2'b00 && cyc < 40);
        chk("timeout_cycles", 32'(cyc), 32'd16);
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_break", 32'(data_break), 32'd0);
        req[0] = 1'b0;
        @(negedge clk);
        chk("timeout_err_clr", 32'(err), 32'd0);
        @(negedge clk);

        // Clear mid-BREAK; last winner was 0, so 1 wins first.
        req = 2'b11;
        wait_grant(n);
        chk("pre_clear_gnt", 32'(gnt_id), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        chk("clear_break", 32'(data_break), 32'd0);
        chk("clear_ack", 32'(ack), 32'd0);
        chk("clear_err", 32'(err), 32'd0);
        clear = 1'b0;
        txn(0, 15'o05555, 12'o1234, 1'b1, 2, 12'o1111, 2'b10);
        req = 2'b00;
        @(negedge clk);

        // Reset coincident with DB1.
        req_write[1] = 1'b1;
        req_addr[29:15] = 15'o03333;
        req_wdata[23:12] = 12'o6666;
        req[1] = 1'b1;
        wait_grant(n);
        chk("pre_rst_gnt", 32'(gnt_id), 32'd1);
        st = DB1;
        mem_rdata = 12'o7777;
        reset = 1'b1;
        @(negedge clk);
        chk("rdb1_break", 32'(data_break), 32'd0);
        chk("rdb1_ack", 32'(ack), 32'd0);
        chk("rdb1_err", 32'(err), 32'd0);
        chk("rdb1_rdata", 32'(rdata), 32'd0);
        chk("rdb1_addr", 32'(dmaAddr), 32'd0);
        chk("rdb1_dout", 32'(dmaDOUT), 32'd0);
        chk("rdb1_tomem", 32'(to_mem), 32'd0);
        chk("rdb1_gnt", 32'(gnt_id), 32'd0);
        reset = 1'b0;
        st = 5'd0;
        mem_rdata = 12'd0;
        req = 2'b00;
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
